// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, load/store size encodings and stage control bundle
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 14;

    typedef enum logic [1:0] {
        LS_BYTE    = 2'b00,
        LS_HALF    = 2'b01,
        LS_WORD    = 2'b10,
        LS_ILLEGAL = 2'b11
    } ls_size_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    // Byte accesses can never be misaligned; illegal sizes are handled separately.
    function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] lo);
        return ((size == LS_HALF) && lo[0]) || ((size == LS_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - combinational store-data lane replication and byte-strobe generation
module store_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  ls_size_e          size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb
);

    always_comb begin
        wdata = rdata;
        wstrb = 4'b0000;
        case (size)
            LS_BYTE: begin
                wdata = {(DATA_W / 8){rdata[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            LS_HALF: begin
                wdata = {(DATA_W / 16){rdata[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            LS_WORD: begin
                wstrb = 4'b1111;
            end
            default: begin
                wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with store alignment and bubble/stall control
// Optional misalignment trap compiled in with EX_MEM_MISALIGN_CHECK_EN.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rdata2_i,
    input  logic [4:0]        rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic [2:0]        funct3_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [4:0]        rd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              misalign_o
);

    ls_size_e          size;
    logic [DATA_W-1:0] wdata_n;
    logic [3:0]        strb_n;
    logic              illegal;
    logic              misalign_n;
    logic              mem_ok;
    ctrl_t             ctrl_n;

    assign size    = ls_size_e'(funct3_i[1:0]);
    assign illegal = (size == LS_ILLEGAL);

    store_align #(
        .DATA_W (DATA_W)
    ) u_store_align (
        .size    (size),
        .addr_lo (alu_result_i[1:0]),
        .rdata   (rdata2_i),
        .wdata   (wdata_n),
        .wstrb   (strb_n)
    );

`ifdef EX_MEM_MISALIGN_CHECK_EN
    assign misalign_n = valid_i && (MemRead_i || MemWrite_i) && !illegal
                        && is_misaligned(size, alu_result_i[1:0]);
`else
    assign misalign_n = 1'b0;
`endif

    // A misaligned entry still travels down the pipe, but must not touch memory or the register file.
    assign mem_ok = !illegal && !misalign_n;

    always_comb begin
        ctrl_n            = '0;
        ctrl_n.valid      = valid_i;
        ctrl_n.reg_write  = RegWrite_i && (rd_i != 5'd0) && !misalign_n;
        ctrl_n.mem_read   = MemRead_i && mem_ok;
        ctrl_n.mem_write  = MemWrite_i && mem_ok;
        ctrl_n.mem_to_reg = MemtoReg_i;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_o      <= 1'b0;
            RegWrite_o   <= 1'b0;
            MemRead_o    <= 1'b0;
            MemWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            funct3_o     <= '0;
            alu_result_o <= '0;
            rd_o         <= '0;
            addr_o       <= '0;
            wdata_o      <= '0;
            wstrb_o      <= '0;
            misalign_o   <= 1'b0;
        end else if (flush_i || (!stall_i && !valid_i)) begin
            // Bubble: kill controls only; data fields keep their last values.
            valid_o    <= 1'b0;
            RegWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            wstrb_o    <= '0;
            misalign_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o      <= ctrl_n.valid;
            RegWrite_o   <= ctrl_n.reg_write;
            MemRead_o    <= ctrl_n.mem_read;
            MemWrite_o   <= ctrl_n.mem_write;
            MemtoReg_o   <= ctrl_n.mem_to_reg;
            funct3_o     <= funct3_i;
            alu_result_o <= alu_result_i;
            rd_o         <= rd_i;
            addr_o       <= addr_i;
            wdata_o      <= wdata_n;
            wstrb_o      <= ctrl_n.mem_write ? strb_n : 4'b0000;
            misalign_o   <= misalign_n;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed vector table plus stall/reset sequences for ex_mem_stage
module tb_ex_mem_stage;

`ifdef EX_MEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, valid_i;
    logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i, rdata2_i;
    logic [4:0]  rd_i;
    logic [13:0] addr_i;
    logic        valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;
    logic [2:0]  funct3_o;
    logic [31:0] alu_result_o, wdata_o;
    logic [4:0]  rd_o;
    logic [13:0] addr_o;
    logic [3:0]  wstrb_o;
    logic        misalign_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .ADDR_W(14)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .RegWrite_i   (RegWrite_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .funct3_i     (funct3_i),
        .alu_result_i (alu_result_i),
        .rdata2_i     (rdata2_i),
        .rd_i         (rd_i),
        .addr_i       (addr_i),
        .valid_o      (valid_o),
        .RegWrite_o   (RegWrite_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .funct3_o     (funct3_o),
        .alu_result_o (alu_result_o),
        .rd_o         (rd_o),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .wstrb_o      (wstrb_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic        stall, flush, valid, rw, mr, mw, m2r;
        logic [2:0]  f3;
        logic [31:0] alu, rd2;
        logic [4:0]  rd;
        logic [13:0] addr;
        logic        e_valid, e_rw, e_mr, e_mw, e_m2r;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_mis;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic mr, input logic mw, input logic m2r, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
                         input logic [13:0] addr);
        stall_i = st; flush_i = fl; valid_i = v; RegWrite_i = rw; MemRead_i = mr;
        MemWrite_i = mw; MemtoReg_i = m2r; funct3_i = f3; alu_result_i = alu;
        rdata2_i = rd2; rd_i = rd; addr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic rw, input logic mr,
                           input logic mw, input logic m2r, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [4:0] rd, input logic [13:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws, input logic mis);
        chk({tag, " valid_o"},      valid_o,      v);
        chk({tag, " RegWrite_o"},   RegWrite_o,   rw);
        chk({tag, " MemRead_o"},    MemRead_o,    mr);
        chk({tag, " MemWrite_o"},   MemWrite_o,   mw);
        chk({tag, " MemtoReg_o"},   MemtoReg_o,   m2r);
        chk({tag, " funct3_o"},     funct3_o,     f3);
        chk({tag, " alu_result_o"}, alu_result_o, alu);
        chk({tag, " rd_o"},         rd_o,         rd);
        chk({tag, " addr_o"},       addr_o,       addr);
        chk({tag, " wdata_o"},      wdata_o,      wd);
        chk({tag, " wstrb_o"},      wstrb_o,      ws);
        chk({tag, " misalign_o"},   misalign_o,   mis);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          st fl v  rw mr mw m2r f3      alu          rdata2        rd    addr     ev erw emr emw em2r ewdata        ewstrb            emis ealu         erd
        vecs[0]  = '{0, 0, 1, 0, 0, 1, 0, 3'b000, 32'h3,       32'hA5,       5'd0, 14'h010, 1, 0, 0, 1,    0, 32'hA5A5A5A5, 4'b1000,          0,   32'h3,       5'd0};
        vecs[1]  = '{0, 0, 1, 0, 0, 1, 0, 3'b001, 32'h2,       32'h1234ABCD, 5'd0, 14'h011, 1, 0, 0, 1,    0, 32'hABCDABCD, 4'b1100,          0,   32'h2,       5'd0};
        vecs[2]  = '{0, 0, 1, 0, 0, 1, 0, 3'b010, 32'h100,     32'hDEADBEEF, 5'd0, 14'h012, 1, 0, 0, 1,    0, 32'hDEADBEEF, 4'b1111,          0,   32'h100,     5'd0};
        vecs[3]  = '{0, 0, 1, 1, 1, 0, 1, 3'b010, 32'h44,      32'h11111111, 5'd5, 14'h013, 1, 1, 1, 0,    1, 32'h11111111, 4'b0000,          0,   32'h44,      5'd5};
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 0, 3'b000, 32'h7,       32'h22,       5'd0, 14'h014, 1, 0, 0, 0,    0, 32'h22222222, 4'b0000,          0,   32'h7,       5'd0};
        vecs[5]  = '{0, 0, 1, 1, 0, 1, 0, 3'b011, 32'h8,       32'h55667788, 5'd3, 14'h015, 1, 1, 0, 0,    0, 32'h55667788, 4'b0000,          0,   32'h8,       5'd3};
        vecs[6]  = '{0, 0, 1, 1, 1, 0, 1, 3'b100, 32'h1001,    32'h0,        5'd9, 14'h016, 1, 1, 1, 0,    1, 32'h0,        4'b0000,          0,   32'h1001,    5'd9};
        vecs[7]  = '{0, 0, 1, 0, 0, 1, 0, 3'b001, 32'h101,     32'hBEEF,     5'd0, 14'h017, 1, 0, 0, !MIS, 0, 32'hBEEFBEEF, MIS ? 4'b0000 : 4'b0011, MIS, 32'h101, 5'd0};
        vecs[8]  = '{0, 0, 1, 1, 1, 0, 1, 3'b010, 32'h102,     32'h0,        5'd4, 14'h018, 1, !MIS, !MIS, 0, 1, 32'h0,     4'b0000,          MIS, 32'h102,     5'd4};
        vecs[9]  = '{0, 0, 0, 1, 1, 1, 1, 3'b000, 32'h55,      32'h99,       5'd7, 14'h019, 0, 0, 0, 0,    0, 32'h0,        4'b0000,          0,   32'h102,     5'd4};
        vecs[10] = '{0, 1, 1, 1, 1, 0, 1, 3'b010, 32'h60,      32'h77,       5'd6, 14'h01A, 0, 0, 0, 0,    0, 32'h0,        4'b0000,          0,   32'h102,     5'd4};
        vecs[11] = '{0, 0, 1, 1, 1, 0, 0, 3'b010, 32'h20,      32'h3,        5'd2, 14'h01B, 1, 1, 1, 0,    0, 32'h3,        4'b0000,          0,   32'h20,      5'd2};
        vecs[12] = '{1, 1, 1, 1, 1, 0, 1, 3'b010, 32'h30,      32'h4,        5'd8, 14'h01C, 0, 0, 0, 0,    0, 32'h3,        4'b0000,          0,   32'h20,      5'd2};
        vecs[13] = '{1, 0, 1, 0, 0, 1, 0, 3'b000, 32'h40,      32'h5,        5'd1, 14'h01D, 0, 0, 0, 0,    0, 32'h3,        4'b0000,          0,   32'h20,      5'd2};

        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 14'h0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1 chk_all("reset async", 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 14'h0, 32'h0, 4'h0, 0);
        drive(0, 0, 1, 1, 1, 1, 1, 3'b010, 32'hFFFF, 32'hFFFF, 5'd3, 14'h3FF);
        tick();
        chk_all("reset clocked", 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 14'h0, 32'h0, 4'h0, 0);
        rst_n = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].mr,
                  vecs[i].mw, vecs[i].m2r, vecs[i].f3, vecs[i].alu, vecs[i].rd2,
                  vecs[i].rd, vecs[i].addr);
            tick();
            chk($sformatf("v%0d valid_o", i),      valid_o,      vecs[i].e_valid);
            chk($sformatf("v%0d RegWrite_o", i),   RegWrite_o,   vecs[i].e_rw);
            chk($sformatf("v%0d MemRead_o", i),    MemRead_o,    vecs[i].e_mr);
            chk($sformatf("v%0d MemWrite_o", i),   MemWrite_o,   vecs[i].e_mw);
            chk($sformatf("v%0d MemtoReg_o", i),   MemtoReg_o,   vecs[i].e_m2r);
            chk($sformatf("v%0d wdata_o", i),      wdata_o,      vecs[i].e_wdata);
            chk($sformatf("v%0d wstrb_o", i),      wstrb_o,      vecs[i].e_wstrb);
            chk($sformatf("v%0d misalign_o", i),   misalign_o,   vecs[i].e_mis);
            chk($sformatf("v%0d alu_result_o", i), alu_result_o, vecs[i].e_alu);
            chk($sformatf("v%0d rd_o", i),         rd_o,         vecs[i].e_rd);
        end

        // Word store, then three stalled cycles with churning inputs.
        drive(0, 0, 1, 0, 0, 1, 0, 3'b010, 32'h200, 32'hCAFEF00D, 5'd0, 14'h123);
        tick();
        chk_all("stall load", 1, 0, 0, 1, 0, 3'b010, 32'h200, 5'd0, 14'h123, 32'hCAFEF00D, 4'hF, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, c[0], 1, 1, c[0], 1, 3'(c), 32'h300 + 32'(c), $urandom, 5'(c + 10), 14'(c + 7));
            tick();
            chk_all($sformatf("stall c%0d", c), 1, 0, 0, 1, 0, 3'b010, 32'h200, 5'd0, 14'h123,
                    32'hCAFEF00D, 4'hF, 0);
        end

        // Reset pulse between edges while the stage holds a valid entry, under stall.
        drive(0, 0, 1, 1, 1, 0, 1, 3'b010, 32'h80, 32'h1, 5'd1, 14'h2A);
        tick();
        chk("pre-reset valid_o", valid_o, 1'b1);
        stall_i = 1'b1;
        #2 rst_n = 1'b1;
        #1 chk_all("mid-cycle reset", 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 14'h0, 32'h0, 4'h0, 0);
        #1 rst_n = 1'b0;
        tick();
        chk("post-reset stall valid_o", valid_o, 1'b0);
        chk("post-reset stall alu_result_o", alu_result_o, 32'h0);
        drive(0, 0, 1, 1, 1, 0, 1, 3'b010, 32'h84, 32'h1, 5'd1, 14'h2B);
        tick();
        chk_all("resume", 1, 1, 1, 0, 1, 3'b010, 32'h84, 5'd1, 14'h2B, 32'h1, 4'h0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter ADDR_W, default 14, instruction-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset: asynchronous, active-high (1 = reset).
REQ-005 SHALL have port stall_i  input  1  hold all registered state this cycle.
REQ-006 SHALL have port flush_i  input  1  replace stage contents with a bubble.
REQ-007 SHALL have port valid_i  input  1  EX-stage instruction valid.
REQ-008 SHALL have ports RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  input  1 each  EX-stage control.
REQ-009 SHALL have port funct3_i  input  3  load/store size: bits[1:0] 00 byte, 01 half, 10 word, 11 illegal; bit2 unsigned-load flag.
REQ-010 SHALL have ports alu_result_i  input  DATA_W  effective address/result; rdata2_i  input  DATA_W  store source.
REQ-011 SHALL have ports rd_i  input  5  destination register; addr_i  input  ADDR_W  instruction address.
REQ-012 SHALL have outputs valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o (1 each), funct3_o (3), alu_result_o (DATA_W), rd_o (5), addr_o (ADDR_W): registered copies.
REQ-013 SHALL have outputs wdata_o  DATA_W  lane-replicated store data; wstrb_o  4  byte write strobes; misalign_o  1  misaligned-access flag.

Function
REQ-014 SHALL register all outputs on the rising clk edge; latency 1 cycle; no combinational input-to-output path.
REQ-015 SHALL apply per-edge priority: reset > flush_i > stall_i > load.
REQ-016 SHALL, on flush_i, clear valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, wstrb_o and misalign_o; data fields hold their previous values.
REQ-017 SHALL, on stall_i without flush_i, hold every output unchanged.
REQ-018 SHALL, on load with valid_i=0, store a bubble as in REQ-016.
REQ-019 SHALL force RegWrite_o=0 when rd_i=0.
REQ-020 SHALL compute store data by size: byte -> {4{rdata2_i[7:0]}}; half -> {2{rdata2_i[15:0]}}; word -> rdata2_i.
REQ-021 SHALL compute strobes: byte -> 4'b0001<<alu_result_i[1:0]; half -> 4'b0011<<{alu_result_i[1],1'b0}; word -> 4'b1111; illegal size -> 4'b0000.
REQ-022 SHALL drive wstrb_o=0 whenever the loaded MemWrite is 0.
REQ-023 SHALL treat illegal size (funct3_i[1:0]=11) with MemRead_i or MemWrite_i set as a bubble for memory controls (MemRead_o=MemWrite_o=0); RegWrite_o passes unchanged.

Reset
REQ-024 SHALL, while rst_n=1, asynchronously drive every output to 0, independent of clk.
REQ-025 SHALL resume loading on the first rising clk edge after rst_n deasserts; reset mid-stall discards held contents.

Configuration
REQ-026 SHALL compile misalignment checking only when EX_MEM_MISALIGN_CHECK_EN is defined.
REQ-027 SHALL, with the macro defined, set misalign_o=1 for half with alu_result_i[0]=1 or word with alu_result_i[1:0]!=0 on a valid memory op, and force MemRead_o, MemWrite_o, RegWrite_o and wstrb_o to 0 for that entry.
REQ-028 SHALL, without the macro, tie misalign_o to 0 and pass misaligned accesses unsuppressed with strobes per REQ-021.

Structure
REQ-029 SHALL place DATA_W default, ADDR_W default and the size encodings LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10 in shared package cpu_pkg.
REQ-030 SHALL implement REQ-020/REQ-021 in a combinational sub-module store_align, instantiated once.

Verification
REQ-031 Bench SHALL drive a byte store, rdata2_i=32'h000000A5, alu_result_i=32'h00000003 -> next edge wdata_o=32'hA5A5A5A5, wstrb_o=4'b1000, MemWrite_o=1.
REQ-032 Bench SHALL assert stall_i and flush_i together with a valid load pending -> valid_o=0, MemRead_o=0 after the edge.
REQ-033 Bench SHALL load a word store, then hold stall_i for 3 cycles with changing inputs -> all outputs constant for 3 cycles.
REQ-034 Bench SHALL drive RegWrite_i=1, rd_i=0, valid_i=1 -> RegWrite_o=0, valid_o=1.
REQ-035 Bench SHALL, with EX_MEM_MISALIGN_CHECK_EN defined, drive a half store at alu_result_i=32'h00000101 -> misalign_o=1, MemWrite_o=0, wstrb_o=0; without the macro -> misalign_o=0, wstrb_o=4'b0011.
REQ-036 Bench SHALL pulse rst_n between clock edges while stage valid -> all outputs read 0 before the next edge.
